// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Optional parity support is selected with UART_TX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int         FIFO_DEPTH_DEF = 16;
    localparam logic [3:0] BIT_TICK_LAST  = 4'd15;
    localparam logic [2:0] DATA_BIT_LAST  = 3'd7;

    localparam logic [1:0] THR_SEL_0 = 2'b00;
    localparam logic [1:0] THR_SEL_2 = 2'b01;
    localparam logic [1:0] THR_SEL_4 = 2'b10;
    localparam logic [1:0] THR_SEL_8 = 2'b11;

    function automatic int unsigned thr_level(input logic [1:0] sel);
        int unsigned lvl;
        lvl = 0;
        unique case (sel)
            THR_SEL_0: lvl = 0;
            THR_SEL_2: lvl = 2;
            THR_SEL_4: lvl = 4;
            THR_SEL_8: lvl = 8;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter.
// Pointers carry one extra wrap bit to tell full from empty.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
)
(
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [7:0]               i_din,
    output logic [7:0]               o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointer update; full is judged before any same-cycle pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: FIFO-buffered 8N1 framing at 16 bclk ticks per bit.
// Define UART_TX_PARITY_EN to add the optional parity bit.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
)
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       bclk,
    input  logic       write_en,
    input  logic [7:0] data_in,
    input  logic       tx_en,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic [1:0] tx_thr_val,
    output logic       txd,
    output logic       tx_bclk_en,
    output logic       tx_ov,
    output logic       tx_thr,
    output logic       tx_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    tx_state_e   r_state;
    tx_state_e   w_state_nxt;
    logic [3:0]  r_tick;
    logic [3:0]  w_tick_nxt;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic        r_txd;
    logic        w_txd_nxt;
    logic        r_tx_ov;
    logic        r_tx_thr;
    logic        w_pop;
    logic        w_bit_end;
    logic        w_can_start;
    logic [7:0]  w_fifo_dout;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [AW:0] w_fifo_level;

`ifdef UART_TX_PARITY_EN
    logic        r_par_en;
    logic        r_par_bit;
`else
    logic        w_unused_par;
    assign w_unused_par = parity_en ^ parity_type;
`endif

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (write_en),
        .i_pop   (w_pop),
        .i_din   (data_in),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level)
    );

    assign w_bit_end   = bclk && (r_tick == BIT_TICK_LAST);
    assign w_can_start = tx_en && !w_fifo_empty;

    assign txd        = r_txd;
    assign tx_bclk_en = (r_state != ST_IDLE);
    assign tx_ov      = r_tx_ov;
    assign tx_thr     = r_tx_thr;
    assign tx_empty   = w_fifo_empty && (r_state == ST_IDLE);

    // Next-state, tick/bit counters and shifter; a pop loads a new frame.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        if (r_state != ST_IDLE && bclk) w_tick_nxt = r_tick + 4'd1;
        unique case (r_state)
            ST_IDLE: begin
                if (w_can_start) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_dout;
                    w_tick_nxt  = 4'd0;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == DATA_BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_end) w_state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (w_bit_end) begin
                    if (w_can_start) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_dout;
                        w_tick_nxt  = 4'd0;
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Line level for the coming cycle, decoded from the next state.
    always_comb begin
        w_txd_nxt = 1'b1;
        unique case (w_state_nxt)
            ST_START:  w_txd_nxt = 1'b0;
            ST_DATA:   w_txd_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_txd_nxt = r_par_bit;
`endif
            default:   w_txd_nxt = 1'b1;
        endcase
    end

    // FSM and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_tick  <= 4'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity settings are frozen per frame at the moment of the pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_pop) begin
            r_par_en  <= parity_en;
            r_par_bit <= (^w_fifo_dout) ^ parity_type;
        end
    end
`endif

    // Status flags: overflow pulse and registered almost-empty level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tx_ov  <= 1'b0;
            r_tx_thr <= 1'b1;
        end else begin
            r_tx_ov  <= write_en && w_fifo_full;
            r_tx_thr <= (32'(w_fifo_level) <= thr_level(tx_thr_val));
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with a bit-level scoreboard.
// Frame expectations follow UART_TX_PARITY_EN when it is defined.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       resetn;
    logic       bclk;
    logic       write_en;
    logic [7:0] data_in;
    logic       tx_en;
    logic       parity_en;
    logic       parity_type;
    logic [1:0] tx_thr_val;
    logic       txd;
    logic       tx_bclk_en;
    logic       tx_ov;
    logic       tx_thr;
    logic       tx_empty;

    int total = 0;
    int bad   = 0;
    int pcnt  = 0;
    bit hit   = 0;
    bit exp_q[$];
    int len_q[$];

    uart_transmitter #(.FIFO_DEPTH(16)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bclk        (bclk),
        .write_en    (write_en),
        .data_in     (data_in),
        .tx_en       (tx_en),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .tx_thr_val  (tx_thr_val),
        .txd         (txd),
        .tx_bclk_en  (tx_bclk_en),
        .tx_ov       (tx_ov),
        .tx_thr      (tx_thr),
        .tx_empty    (tx_empty)
    );

    always #5 clk = ~clk;

    // bclk: one-cycle tick every third clock
    initial begin
        int div;
        div = 0;
        bclk = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div = (div == 2) ? 0 : div + 1;
            bclk = (div == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        hit = bclk;
        if (bclk) pcnt++;
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        write_en = 1'b1;
        data_in  = b;
        step();
        write_en = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] b, input bit pe, input bit pt);
        int n;
        n = 10;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        if (pe) begin
            exp_q.push_back((^b) ^ pt);
            n = 11;
        end
`else
        if (pe || pt) n = 10;
`endif
        exp_q.push_back(1'b1);
        len_q.push_back(n);
    endtask

    task automatic recv(input bit started, input bit b2b, input string tag);
        int n;
        bit e;
        if (!started) begin
            int w;
            w = 0;
            while (txd !== 1'b0 && w < 400) begin
                step();
                w++;
            end
            chk({tag, " start_edge"}, 32'(txd), 32'd0);
            pcnt = 0;
        end
        n = (len_q.size() > 0) ? len_q.pop_front() : 10;
        for (int b = 0; b < n; b++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
            while (pcnt < 16) begin
                step();
                if (hit && pcnt == 1)
                    chk($sformatf("%s bit%0d head", tag, b), 32'(txd), 32'(e));
                if (hit && pcnt == 15)
                    chk($sformatf("%s bit%0d tail", tag, b), 32'(txd), 32'(e));
            end
            pcnt = 0;
        end
        chk({tag, " after_stop"}, 32'(txd), b2b ? 32'd0 : 32'd1);
        chk({tag, " bclk_en"}, 32'(tx_bclk_en), 32'(b2b));
    endtask

    initial begin
        bit seen_low;
        bit seen_act;
        resetn      = 1'b0;
        write_en    = 1'b0;
        data_in     = 8'h00;
        tx_en       = 1'b0;
        parity_en   = 1'b0;
        parity_type = 1'b0;
        tx_thr_val  = 2'b00;

        // reset state
        step();
        step();
        chk("rst txd", 32'(txd), 32'd1);
        chk("rst bclk_en", 32'(tx_bclk_en), 32'd0);
        chk("rst ov", 32'(tx_ov), 32'd0);
        chk("rst thr", 32'(tx_thr), 32'd1);
        chk("rst empty", 32'(tx_empty), 32'd1);
        resetn = 1'b1;
        step();

        // 0x55, no parity, latency from write to start bit
        tx_en = 1'b1;
        push_frame(8'h55, 1'b0, 1'b0);
        wr(8'h55);
        chk("lat N+1 txd", 32'(txd), 32'd1);
        step();
        pcnt = 0;
        chk("lat N+2 txd", 32'(txd), 32'd0);
        chk("lat bclk_en", 32'(tx_bclk_en), 32'd1);
        recv(1'b1, 1'b0, "f55");
        chk("f55 empty", 32'(tx_empty), 32'd1);

        // parity even then odd; settings changed mid-frame are ignored
        parity_en   = 1'b1;
        parity_type = 1'b0;
        push_frame(8'h07, 1'b1, 1'b0);
        wr(8'h07);
        step();
        pcnt = 0;
        parity_type = 1'b1;
        parity_en   = 1'b0;
        recv(1'b1, 1'b0, "par_even");
        parity_en   = 1'b1;
        parity_type = 1'b1;
        push_frame(8'h07, 1'b1, 1'b1);
        wr(8'h07);
        step();
        pcnt = 0;
        parity_type = 1'b0;
        parity_en   = 1'b0;
        recv(1'b1, 1'b0, "par_odd");

        // three back-to-back frames
        push_frame(8'hA1, 1'b0, 1'b0);
        push_frame(8'h3E, 1'b0, 1'b0);
        push_frame(8'hC4, 1'b0, 1'b0);
        write_en = 1'b1;
        data_in  = 8'hA1;
        step();
        data_in = 8'h3E;
        step();
        pcnt = 0;
        data_in = 8'hC4;
        step();
        write_en = 1'b0;
        recv(1'b1, 1'b1, "b2b0");
        recv(1'b1, 1'b1, "b2b1");
        chk("b2b mid empty", 32'(tx_empty), 32'd0);
        recv(1'b1, 1'b0, "b2b2");
        chk("b2b end empty", 32'(tx_empty), 32'd1);

        // threshold select 01 around level 2/3; tx_en drop mid-frame
        tx_en      = 1'b0;
        tx_thr_val = 2'b01;
        push_frame(8'h96, 1'b0, 1'b0);
        wr(8'h96);
        wr(8'h11);
        wr(8'h22);
        chk("thr lvl2", 32'(tx_thr), 32'd1);
        step();
        chk("thr lvl3", 32'(tx_thr), 32'd0);
        chk("thr idle", 32'(tx_bclk_en), 32'd0);
        tx_en = 1'b1;
        step();
        pcnt = 0;
        tx_en = 1'b0;
        recv(1'b1, 1'b0, "thr_frame");
        chk("thr after pop", 32'(tx_thr), 32'd1);
        chk("thr nonempty", 32'(tx_empty), 32'd0);
        repeat (40) step();
        chk("txen off idle", 32'(tx_bclk_en), 32'd0);

        // reset discards queued bytes
        resetn = 1'b0;
        #1;
        chk("discard empty", 32'(tx_empty), 32'd1);
        step();
        resetn = 1'b1;
        tx_en  = 1'b1;
        repeat (40) step();
        chk("discard idle", 32'(tx_bclk_en), 32'd0);
        chk("discard txd", 32'(txd), 32'd1);
        tx_en = 1'b0;

        // overflow: 16 fill, 17th dropped, 18th dropped despite a pop
        tx_thr_val = 2'b11;
        for (int i = 0; i < 16; i++) begin
            push_frame(8'h10 + 8'(i), 1'b0, 1'b0);
            wr(8'h10 + 8'(i));
        end
        chk("ov fill16", 32'(tx_ov), 32'd0);
        wr(8'hEE);
        chk("ov w17", 32'(tx_ov), 32'd1);
        step();
        chk("ov pulse end", 32'(tx_ov), 32'd0);
        chk("ov level", 32'(dut.u_fifo.o_level), 32'd16);
        chk("ov thr", 32'(tx_thr), 32'd0);
        write_en = 1'b1;
        data_in  = 8'hEF;
        tx_en    = 1'b1;
        step();
        pcnt = 0;
        write_en = 1'b0;
        chk("ov w18 pop", 32'(tx_ov), 32'd1);
        chk("ov w18 start", 32'(txd), 32'd0);
        step();
        chk("ov w18 end", 32'(tx_ov), 32'd0);
        for (int i = 0; i < 16; i++)
            recv(1'b1, (i < 15), $sformatf("ovf%0d", i));
        chk("ov drained", 32'(tx_empty), 32'd1);
        repeat (40) step();
        chk("ov no extra", 32'(tx_bclk_en), 32'd0);

        // reset during data bit 4
        wr(8'h2C);
        wr(8'hA5);
        pcnt = 0;
        while (pcnt < 88) step();
        chk("mid bit4", 32'(txd), 32'd0);
        chk("mid active", 32'(tx_bclk_en), 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid rst txd", 32'(txd), 32'd1);
        chk("mid rst bclk_en", 32'(tx_bclk_en), 32'd0);
        chk("mid rst empty", 32'(tx_empty), 32'd1);
        step();
        step();
        resetn = 1'b1;
        seen_low = 1'b0;
        seen_act = 1'b0;
        repeat (80) begin
            step();
            if (txd !== 1'b1) seen_low = 1'b1;
            if (tx_bclk_en !== 1'b0) seen_act = 1'b1;
        end
        chk("post rst txd", 32'(seen_low), 32'd0);
        chk("post rst act", 32'(seen_act), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
